// File: rtl/vga_mem_arbiter.sv
// Single-port image memory arbiter: display reads have absolute priority and a fixed
// 3-cycle latency; the host gets leftover cycles. Define VGA_ARB_STATS_EN for grant/busy counters.
module vga_mem_arbiter #(
  parameter int AW             = 16,
  parameter int DW             = 8,
  parameter int WR_VBLANK_ONLY = 0,
  parameter int STALL_LIMIT    = 1023
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          vblank,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          host_starve,
  input  logic          starve_clr,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef VGA_ARB_STATS_EN
  output logic [31:0]   host_grant_cnt,
  output logic [31:0]   disp_busy_cnt,
`endif
  output logic [1:0]    dbg_state
);

  // Handshake: a host transfer happens on a cycle where host_valid && host_ready;
  // host_ready never looks at host_valid, and the host holds valid/payload until accepted.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISP    = 2'd1,
    ST_HOST_RD = 2'd2,
    ST_HOST_WR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_HOST = 2'd2
  } tag_t;

  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(STALL_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STALL_LIMIT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] iss_addr_q, iss_addr_d;
  logic [DW-1:0] iss_wdata_q, iss_wdata_d;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  tag_t          tag0_q, tag0_d;
  tag_t          tag1_q;

  logic [DW-1:0] disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          starve_q, starve_d;

  logic host_accept;
  logic host_stall;
  logic starve_set;

  assign host_ready  = !disp_req && ((WR_VBLANK_ONLY == 0) || !host_we || vblank);
  assign host_accept = host_valid && host_ready;
  assign host_stall  = host_valid && !host_ready;

  // Issue stage: owner of the memory slot one cycle ahead of the memory port.
  always_comb begin
    state_d     = ST_IDLE;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    if (disp_req) begin
      state_d    = ST_DISP;
      iss_addr_d = disp_addr;
    end else if (host_accept) begin
      state_d    = host_we ? ST_HOST_WR : ST_HOST_RD;
      iss_addr_d = host_addr;
      if (host_we) begin
        iss_wdata_d = host_wdata;
      end
    end
  end

  // Memory port stage plus the tag that travels with each read.
  always_comb begin
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag0_d      = TAG_NONE;
    case (state_q)
      ST_DISP: begin
        mem_re_d   = 1'b1;
        mem_addr_d = iss_addr_q;
        tag0_d     = TAG_DISP;
      end
      ST_HOST_RD: begin
        mem_re_d   = 1'b1;
        mem_addr_d = iss_addr_q;
        tag0_d     = TAG_HOST;
      end
      ST_HOST_WR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = iss_addr_q;
        mem_wdata_d = iss_wdata_q;
      end
      default: begin
        mem_re_d = 1'b0;
      end
    endcase
  end

  // Return routing: tag1 lines up with mem_rdata, so each word goes to exactly one sink.
  always_comb begin
    disp_valid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    disp_data_d   = disp_data_q;
    host_rdata_d  = host_rdata_q;
    if (tag1_q == TAG_DISP) begin
      disp_valid_d = 1'b1;
      disp_data_d  = mem_rdata;
    end else if (tag1_q == TAG_HOST) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_rdata;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    starve_set  = 1'b0;
    if (!host_valid || host_accept) begin
      stall_cnt_d = '0;
    end else if (host_stall) begin
      if (stall_cnt_q != LIMIT) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      starve_set = (stall_cnt_q >= LIMIT_M1);
    end
    if (starve_clr) begin
      starve_d = 1'b0;
    end else begin
      starve_d = starve_q | starve_set;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_IDLE;
      iss_addr_q    <= '0;
      iss_wdata_q   <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      tag0_q        <= TAG_NONE;
      tag1_q        <= TAG_NONE;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      stall_cnt_q   <= '0;
      starve_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      iss_addr_q    <= iss_addr_d;
      iss_wdata_q   <= iss_wdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      tag0_q        <= tag0_d;
      tag1_q        <= tag0_q;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      stall_cnt_q   <= stall_cnt_d;
      starve_q      <= starve_d;
    end
  end

`ifdef VGA_ARB_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    if (starve_clr) begin
      grant_cnt_d = '0;
      busy_cnt_d  = '0;
    end else begin
      if (host_accept) grant_cnt_d = grant_cnt_q + 32'd1;
      if (disp_req)    busy_cnt_d  = busy_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      grant_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign host_grant_cnt = grant_cnt_q;
  assign disp_busy_cnt  = busy_cnt_q;
`endif

  assign disp_data   = disp_data_q;
  assign disp_valid  = disp_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_starve = starve_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: sync RAM model, strobe scoreboards and
// step-by-step latency/priority/starvation checks.
module tb_vga_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          CLK, RSTN;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          vblank;
  logic          host_valid, host_ready, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_rvalid, host_starve, starve_clr;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;
`ifdef VGA_ARB_STATS_EN
  logic [31:0]   host_grant_cnt, disp_busy_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int disp_strobes = 0;
  int host_strobes = 0;

  logic [DW-1:0] disp_exp_q[$];
  logic [DW-1:0] host_exp_q[$];
  logic [DW-1:0] wmem[int];

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .WR_VBLANK_ONLY(1), .STALL_LIMIT(8)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .vblank(vblank),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_starve(host_starve), .starve_clr(starve_clr),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef VGA_ARB_STATS_EN
    .host_grant_cnt(host_grant_cnt), .disp_busy_cnt(disp_busy_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Preload contents of the image memory before any host write.
  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    if (a == 16'h0010) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return init_pat(a);
  endfunction

  // Synchronous single-port RAM, 1-cycle read latency.
  always @(posedge CLK) begin
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
    if (mem_re) mem_rdata <= mem_model(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every return strobe must match the oldest expected word for its sink.
  always @(negedge CLK) begin
    if (RSTN && disp_valid) begin
      disp_strobes++;
      if (disp_exp_q.size() == 0) check("disp_unexpected_strobe", 32'd1, 32'd0);
      else check("disp_data_sb", {24'd0, disp_data}, {24'd0, disp_exp_q.pop_front()});
    end
    if (RSTN && host_rvalid) begin
      host_strobes++;
      if (host_exp_q.size() == 0) check("host_unexpected_strobe", 32'd1, 32'd0);
      else check("host_rdata_sb", {24'd0, host_rdata}, {24'd0, host_exp_q.pop_front()});
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    disp_req   = 1'b0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    starve_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},    {16'd0, mem_addr},   32'd0);
    check({tag, "_mem_re"},      {31'd0, mem_re},     32'd0);
    check({tag, "_mem_we"},      {31'd0, mem_we},     32'd0);
    check({tag, "_mem_wdata"},   {24'd0, mem_wdata},  32'd0);
    check({tag, "_disp_data"},   {24'd0, disp_data},  32'd0);
    check({tag, "_disp_valid"},  {31'd0, disp_valid}, 32'd0);
    check({tag, "_host_rdata"},  {24'd0, host_rdata}, 32'd0);
    check({tag, "_host_rvalid"}, {31'd0, host_rvalid},32'd0);
    check({tag, "_host_starve"}, {31'd0, host_starve},32'd0);
    check({tag, "_state"},       {30'd0, dbg_state},  32'd0);
  endtask

  int d_before, h_before;

  initial begin
    RSTN = 1'b0; vblank = 1'b1;
    disp_addr = '0; host_addr = '0; host_wdata = '0;
    idle_inputs();
    step(); step();
    check_all_zero("por");
    RSTN = 1'b1;
    step(); step();

    // Reset while a display read is in flight: no strobe may ever appear.
    disp_req = 1'b1; disp_addr = 16'h0010;
    step();
    disp_req = 1'b0;
    step();
    check("rst_mid_mem_re", {31'd0, mem_re}, 32'd1);
    RSTN = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step(); step();
    RSTN = 1'b1;
    d_before = disp_strobes;
    repeat (6) step();
    check("rst_mid_no_strobe", disp_strobes, d_before);

    // Display latency: request at edge N, strobe after edge N+3.
    disp_req = 1'b1; disp_addr = 16'h0010;
    disp_exp_q.push_back(8'hA5);
    #1 check("lat_ready_low", {31'd0, host_ready}, 32'd0);
    step();
    disp_req = 1'b0;
    check("lat_n0_mem_re", {31'd0, mem_re}, 32'd0);
    step();
    check("lat_n1_mem_re", {31'd0, mem_re}, 32'd1);
    check("lat_n1_mem_addr", {16'd0, mem_addr}, 32'h0010);
    step();
    check("lat_n2_valid", {31'd0, disp_valid}, 32'd0);
    step();
    check("lat_n3_valid", {31'd0, disp_valid}, 32'd1);
    check("lat_n3_data", {24'd0, disp_data}, 32'h00A5);
    step();
    check("lat_n4_valid", {31'd0, disp_valid}, 32'd0);
    check("lat_n4_hold", {24'd0, disp_data}, 32'h00A5);

    // Conflict: host write held against 4 display cycles.
    vblank = 1'b1;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      disp_req = 1'b1; disp_addr = 16'h0100 + 16'(i);
      disp_exp_q.push_back(init_pat(16'h0100 + 16'(i)));
      #1 check("cfl_ready_low", {31'd0, host_ready}, 32'd0);
      step();
    end
    disp_req = 1'b0;
    #1 check("cfl_ready_high", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0; host_we = 1'b0;
    check("cfl_n0_we", {31'd0, mem_we}, 32'd0);
    step();
    check("cfl_n1_we", {31'd0, mem_we}, 32'd1);
    check("cfl_n1_addr", {16'd0, mem_addr}, 32'h0020);
    check("cfl_n1_wdata", {24'd0, mem_wdata}, 32'h003C);
    step();
    check("cfl_n2_we", {31'd0, mem_we}, 32'd0);
    check("cfl_no_starve", {31'd0, host_starve}, 32'd0);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
    host_exp_q.push_back(8'h3C);
    #1 check("rb_ready", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0;
    step(); step(); step();
    check("rb_rvalid", {31'd0, host_rvalid}, 32'd1);
    check("rb_rdata", {24'd0, host_rdata}, 32'h003C);
    step();

    // Interleave display and host reads every other cycle.
    d_before = disp_strobes; h_before = host_strobes;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        disp_req = 1'b1; host_valid = 1'b0; disp_addr = 16'h0200 + 16'(i);
        disp_exp_q.push_back(init_pat(16'h0200 + 16'(i)));
      end else begin
        disp_req = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0300 + 16'(i);
        host_exp_q.push_back(init_pat(16'h0300 + 16'(i)));
        #1 check("ilv_ready", {31'd0, host_ready}, 32'd1);
      end
      step();
    end
    idle_inputs();
    repeat (5) step();
    check("ilv_disp_count", disp_strobes - d_before, 32'd8);
    check("ilv_host_count", host_strobes - h_before, 32'd8);

    // Writes wait for vblank; reads do not.
    vblank = 1'b0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 8'h77;
    #1 check("vb_wr_blocked", {31'd0, host_ready}, 32'd0);
    step();
    check("vb_wr_no_we", {31'd0, mem_we}, 32'd0);
    vblank = 1'b1;
    #1 check("vb_wr_ready", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0; host_we = 1'b0; vblank = 1'b0;
    step();
    check("vb_wr_we", {31'd0, mem_we}, 32'd1);
    check("vb_wr_addr", {16'd0, mem_addr}, 32'h0040);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0040;
    host_exp_q.push_back(8'h77);
    #1 check("vb_rd_ready", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0;
    repeat (4) step();

    // Starvation with limit 8, sticky flag, clear wins over simultaneous set.
    disp_req = 1'b1; disp_addr = 16'h0010;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0050;
    for (int i = 1; i <= 8; i++) begin
      disp_exp_q.push_back(8'hA5);
      step();
      check("stv_count", {31'd0, host_starve}, (i == 8) ? 32'd1 : 32'd0);
    end
    disp_exp_q.push_back(8'hA5);
    step();
    check("stv_sticky", {31'd0, host_starve}, 32'd1);
    disp_exp_q.push_back(8'hA5);
    starve_clr = 1'b1;
    step();
    check("stv_clr_prio", {31'd0, host_starve}, 32'd0);
    idle_inputs();
    step();
    check("stv_after_clr", {31'd0, host_starve}, 32'd0);
    repeat (5) step();

    check("final_disp_q_empty", disp_exp_q.size(), 32'd0);
    check("final_host_q_empty", host_exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
